// File: rtl/cpu_control_sequencer_pkg.sv
// rtl/cpu_control_sequencer_pkg.sv - state encodings, opcodes and IR field positions for the CPU control sequencer
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_NOP     = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_SHRA = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_ROL  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_HI = 31;
  localparam int RA_HI  = 26;
  localparam int RB_HI  = 22;
  localparam int RC_HI  = 18;
  localparam int REG_W  = 4;

  // Opcodes from OP_ADD through OP_ROL all share the three-step R-format path.
  function automatic op_class_t classify(input logic [4:0] op);
    if (op >= OP_ADD && op <= OP_ROL) return CLS_ALU;
    case (op)
      OP_MUL, OP_DIV: return CLS_MULDIV;
      OP_NOP:         return CLS_NOP;
      OP_HALT:        return CLS_HALT;
      default:        return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// rtl/cpu_control_sequencer_if.sv - control strobe bundle between sequencer (master) and datapath (slave)
interface cpu_control_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
);
  logic [31:0]         IR;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic Yin, Yout, Zin, ZLOin, ZHIin, ZLowSelect, ZLOout, ZHIout;
  logic HIin, Loin;
  logic [OP_W-1:0]     ALUSelection;
  logic done, halted;

  modport master (
    input  IR,
    output Rin, Rout,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
    output Yin, Yout, Zin, ZLOin, ZHIin, ZLowSelect, ZLOout, ZHIout,
    output HIin, Loin, ALUSelection, done, halted
  );

  modport slave (
    output IR,
    input  Rin, Rout,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
    input  Yin, Yout, Zin, ZLOin, ZHIin, ZLowSelect, ZLOout, ZHIout,
    input  HIin, Loin, ALUSelection, done, halted
  );
endinterface

// File: rtl/cpu_control_sequencer_reg_select_decoder.sv
// rtl/cpu_control_sequencer_reg_select_decoder.sv - 4-bit register index plus enable to one-hot select
module reg_select_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // Index wraps modulo NUM_REGS so a narrow register file never sees an all-zero select.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && ((int'(idx) % NUM_REGS) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// rtl/cpu_control_sequencer.sv - hardwired fetch/execute control FSM; CTRL_ILLEGAL_TRAP_EN traps illegal opcodes to HALT
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  cpu_control_sequencer_if.master bus
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic illegal_op
`endif
);

  state_t     state, state_nx;
  op_class_t  cls;
  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] ra, rb, rc, rout_idx;
  logic             rout_en, rin_en;
  logic             unused_ir;

  assign opcode    = bus.IR[OPC_HI -: OP_W];
  assign ra        = bus.IR[RA_HI -: REG_W];
  assign rb        = bus.IR[RB_HI -: REG_W];
  assign rc        = bus.IR[RC_HI -: REG_W];
  assign unused_ir = ^bus.IR[RC_HI-REG_W:0];
  assign cls       = classify(5'(opcode));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (run) state_nx = ST_T0;
      ST_T0:   state_nx = ST_T1;
      ST_T1:   state_nx = ST_T2;
      ST_T2:   state_nx = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: state_nx = ST_T4;
          CLS_HALT:            state_nx = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          CLS_ILLEGAL:         state_nx = ST_HALT;
`endif
          default:             state_nx = run ? ST_T0 : ST_IDLE;
        endcase
      end
      ST_T4:   state_nx = ST_T5;
      ST_T5:   state_nx = (cls == CLS_MULDIV) ? ST_T6 : (run ? ST_T0 : ST_IDLE);
      ST_T6:   state_nx = run ? ST_T0 : ST_IDLE;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
    bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.Read = 1'b0; bus.IRin = 1'b0;
    bus.Yin = 1'b0; bus.Yout = 1'b0; bus.Zin = 1'b0; bus.ZLOin = 1'b0;
    bus.ZHIin = 1'b0; bus.ZLowSelect = 1'b0; bus.ZLOout = 1'b0; bus.ZHIout = 1'b0;
    bus.HIin = 1'b0; bus.Loin = 1'b0; bus.done = 1'b0;
    bus.ALUSelection = '0;
    bus.halted = (state == ST_HALT);
    rout_en  = 1'b0;
    rout_idx = rb;
    rin_en   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (state)
      ST_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
        bus.Zin = 1'b1; bus.ZLOin = 1'b1;
      end
      ST_T1: begin
        bus.ZLowSelect = 1'b1; bus.ZLOout = 1'b1; bus.PCin = 1'b1;
        bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: begin
            rout_en = 1'b1;
            bus.Yin = 1'b1;
          end
`ifdef CTRL_ILLEGAL_TRAP_EN
          CLS_ILLEGAL: illegal_op = 1'b1;
`endif
          default: bus.done = 1'b1;
        endcase
      end
      ST_T4: begin
        rout_en  = 1'b1;
        rout_idx = rc;
        bus.Yout = 1'b1; bus.Zin = 1'b1; bus.ZLOin = 1'b1;
        bus.ZHIin = (cls == CLS_MULDIV);
        bus.ALUSelection = opcode;
      end
      ST_T5: begin
        bus.ZLowSelect = 1'b1; bus.ZLOout = 1'b1;
        // Mul/div park the low word in LO and finish in T6; ALU ops write ra here.
        if (cls == CLS_MULDIV) begin
          bus.Loin = 1'b1;
        end else begin
          rin_en   = 1'b1;
          bus.done = 1'b1;
        end
      end
      ST_T6: begin
        bus.ZHIout = 1'b1; bus.HIin = 1'b1; bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (bus.Rout)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .idx    (ra),
    .en     (rin_en),
    .onehot (bus.Rin)
  );

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb/tb_cpu_control_sequencer.sv - table-driven directed bench for the CPU control sequencer
module tb_cpu_control_sequencer;

  localparam logic [31:0] I_ADD  = 32'h18A98000;
  localparam logic [31:0] I_SHRA = 32'h48A98000;
  localparam logic [31:0] I_MUL  = 32'h70298000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_ILL  = 32'hF8000000;

  localparam logic [19:0] S_PCOUT   = 20'h80000;
  localparam logic [19:0] S_PCIN    = 20'h40000;
  localparam logic [19:0] S_INCPC   = 20'h20000;
  localparam logic [19:0] S_MARIN   = 20'h10000;
  localparam logic [19:0] S_MDRIN   = 20'h08000;
  localparam logic [19:0] S_MDROUT  = 20'h04000;
  localparam logic [19:0] S_READ    = 20'h02000;
  localparam logic [19:0] S_IRIN    = 20'h01000;
  localparam logic [19:0] S_YIN     = 20'h00800;
  localparam logic [19:0] S_YOUT    = 20'h00400;
  localparam logic [19:0] S_ZIN     = 20'h00200;
  localparam logic [19:0] S_ZLOIN   = 20'h00100;
  localparam logic [19:0] S_ZHIIN   = 20'h00080;
  localparam logic [19:0] S_ZLOWSEL = 20'h00040;
  localparam logic [19:0] S_ZLOOUT  = 20'h00020;
  localparam logic [19:0] S_ZHIOUT  = 20'h00010;
  localparam logic [19:0] S_HIIN    = 20'h00008;
  localparam logic [19:0] S_LOIN    = 20'h00004;
  localparam logic [19:0] S_DONE    = 20'h00002;
  localparam logic [19:0] S_HALTED  = 20'h00001;

  localparam logic [19:0] F_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_ZLOIN;
  localparam logic [19:0] F_T1 = S_ZLOWSEL | S_ZLOOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [19:0] F_T2 = S_MDROUT | S_IRIN;

  typedef struct {
    string       name;
    logic        clr;
    logic        run;
    logic [31:0] ir;
    logic [56:0] exp;
  } vec_t;

  logic clk, clr, run;
  int   errors, checks;
  vec_t vecs[$];
  logic [56:0] got;

  cpu_control_sequencer_if #(.NUM_REGS(16), .OP_W(5)) bus ();

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_op;
  cpu_control_sequencer #(.NUM_REGS(16), .OP_W(5)) dut (
    .clk(clk), .clr(clr), .run(run), .bus(bus), .illegal_op(illegal_op)
  );
`else
  cpu_control_sequencer #(.NUM_REGS(16), .OP_W(5)) dut (
    .clk(clk), .clr(clr), .run(run), .bus(bus)
  );
`endif

  assign got = {bus.Rin, bus.Rout, bus.ALUSelection,
                bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.Read, bus.IRin,
                bus.Yin, bus.Yout, bus.Zin, bus.ZLOin, bus.ZHIin, bus.ZLowSelect, bus.ZLOout, bus.ZHIout,
                bus.HIin, bus.Loin, bus.done, bus.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [56:0] ev(logic [15:0] rin, logic [15:0] rout, logic [4:0] alu, logic [19:0] s);
    return {rin, rout, alu, s};
  endfunction

  function automatic void add_vec(string name, logic c, logic r, logic [31:0] ir, logic [56:0] e);
    vec_t v;
    v.name = name; v.clr = c; v.run = r; v.ir = ir; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [56:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got rin=%h rout=%h alu=%h strobes=%h, expected rin=%h rout=%h alu=%h strobes=%h",
               name, got[56:41], got[40:25], got[24:20], got[19:0], e[56:41], e[40:25], e[24:20], e[19:0]);
    end
  endtask

  // Inputs change on the falling edge; outputs reflect the state latched at the previous rising edge.
  task automatic step(string name, logic c, logic r, logic [31:0] ir, logic [56:0] e);
    @(negedge clk);
    clr = c; run = r; bus.IR = ir;
    #1;
    check(name, e);
  endtask

  initial begin
    errors = 0; checks = 0;
    clr = 1'b1; run = 1'b0; bus.IR = '0;

    add_vec("rst",       1, 1, I_ADD,  ev(0, 0, 0, 0));
    add_vec("idle",      0, 1, I_ADD,  ev(0, 0, 0, 0));
    add_vec("add_t0",    0, 1, I_ADD,  ev(0, 0, 0, F_T0));
    add_vec("add_t1",    0, 1, I_ADD,  ev(0, 0, 0, F_T1));
    add_vec("add_t2",    0, 1, I_ADD,  ev(0, 0, 0, F_T2));
    add_vec("add_t3",    0, 1, I_ADD,  ev(0, 16'h0020, 0, S_YIN));
    add_vec("add_t4",    0, 1, I_ADD,  ev(0, 16'h0008, 5'b00011, S_YOUT | S_ZIN | S_ZLOIN));
    add_vec("add_t5",    0, 1, I_ADD,  ev(16'h0002, 0, 0, S_ZLOWSEL | S_ZLOOUT | S_DONE));
    add_vec("shra_t0",   0, 1, I_SHRA, ev(0, 0, 0, F_T0));
    add_vec("shra_t1",   0, 1, I_SHRA, ev(0, 0, 0, F_T1));
    add_vec("shra_t2",   0, 1, I_SHRA, ev(0, 0, 0, F_T2));
    add_vec("shra_t3",   0, 1, I_SHRA, ev(0, 16'h0020, 0, S_YIN));
    add_vec("shra_t4",   0, 1, I_SHRA, ev(0, 16'h0008, 5'b01001, S_YOUT | S_ZIN | S_ZLOIN));
    add_vec("shra_t5",   0, 0, I_SHRA, ev(16'h0002, 0, 0, S_ZLOWSEL | S_ZLOOUT | S_DONE));
    add_vec("idle_hold", 0, 0, I_SHRA, ev(0, 0, 0, 0));
    add_vec("mul_idle",  0, 1, I_MUL,  ev(0, 0, 0, 0));
    add_vec("mul_t0",    0, 1, I_MUL,  ev(0, 0, 0, F_T0));
    add_vec("mul_t1",    0, 1, I_MUL,  ev(0, 0, 0, F_T1));
    add_vec("mul_t2",    0, 1, I_MUL,  ev(0, 0, 0, F_T2));
    add_vec("mul_t3",    0, 1, I_MUL,  ev(0, 16'h0020, 0, S_YIN));
    add_vec("mul_t4",    0, 0, I_MUL,  ev(0, 16'h0008, 5'b01110, S_YOUT | S_ZIN | S_ZLOIN | S_ZHIIN));
    add_vec("mul_t5",    0, 0, I_MUL,  ev(0, 0, 0, S_ZLOWSEL | S_ZLOOUT | S_LOIN));
    add_vec("mul_t6",    0, 1, I_MUL,  ev(0, 0, 0, S_ZHIOUT | S_HIIN | S_DONE));
    add_vec("nop_t0",    0, 1, I_NOP,  ev(0, 0, 0, F_T0));
    add_vec("nop_t1",    0, 1, I_NOP,  ev(0, 0, 0, F_T1));
    add_vec("nop_t2",    0, 1, I_NOP,  ev(0, 0, 0, F_T2));
    add_vec("nop_t3",    0, 1, I_NOP,  ev(0, 0, 0, S_DONE));
    add_vec("halt_t0",   0, 1, I_HALT, ev(0, 0, 0, F_T0));
    add_vec("halt_t1",   0, 1, I_HALT, ev(0, 0, 0, F_T1));
    add_vec("halt_t2",   0, 1, I_HALT, ev(0, 0, 0, F_T2));
    add_vec("halt_t3",   0, 1, I_HALT, ev(0, 0, 0, S_DONE));

    foreach (vecs[i]) step(vecs[i].name, vecs[i].clr, vecs[i].run, vecs[i].ir, vecs[i].exp);

    for (int k = 0; k < 12; k++) step("halt_hold", 0, 1, I_HALT, ev(0, 0, 0, S_HALTED));
    step("halt_clr", 1, 1, I_HALT, ev(0, 0, 0, 0));
    step("halt_release", 0, 0, I_HALT, ev(0, 0, 0, 0));

    // Abort an add in T4: clear must zero every strobe before the next edge.
    step("abort_idle", 0, 1, I_ADD, ev(0, 0, 0, 0));
    step("abort_t0",   0, 1, I_ADD, ev(0, 0, 0, F_T0));
    step("abort_t1",   0, 1, I_ADD, ev(0, 0, 0, F_T1));
    step("abort_t2",   0, 1, I_ADD, ev(0, 0, 0, F_T2));
    step("abort_t3",   0, 1, I_ADD, ev(0, 16'h0020, 0, S_YIN));
    step("abort_t4",   0, 1, I_ADD, ev(0, 16'h0008, 5'b00011, S_YOUT | S_ZIN | S_ZLOIN));
    clr = 1'b1;
    #1;
    check("abort_clr_now", ev(0, 0, 0, 0));
    for (int k = 0; k < 5; k++) step("abort_after", 0, 0, I_ADD, ev(0, 0, 0, 0));

    step("ill_idle", 0, 1, I_ILL, ev(0, 0, 0, 0));
    step("ill_t0",   0, 1, I_ILL, ev(0, 0, 0, F_T0));
    step("ill_t1",   0, 1, I_ILL, ev(0, 0, 0, F_T1));
    step("ill_t2",   0, 1, I_ILL, ev(0, 0, 0, F_T2));
`ifdef CTRL_ILLEGAL_TRAP_EN
    step("ill_t3",   0, 1, I_ILL, ev(0, 0, 0, 0));
    checks++;
    if (illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL ill_flag: got illegal_op=%b, expected 1", illegal_op);
    end
    step("ill_next", 0, 1, I_ILL, ev(0, 0, 0, S_HALTED));
`else
    step("ill_t3",   0, 1, I_ILL, ev(0, 0, 0, S_DONE));
    step("ill_next", 0, 1, I_ILL, ev(0, 0, 0, F_T0));
`endif
    step("final_clr", 1, 0, I_ILL, ev(0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
